// File: rtl/seg7_pkg.sv
// Shared glyph and BCD constants for the 7-segment capture path.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000011;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  // Candidate value after an illegal glyph; no legal glyph decodes to it.
  localparam logic [3:0] BCD_BAD   = 4'hE;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational glyph decoder: active-low segment pattern to BCD.
// Unknown patterns report legal=0 and decode to BCD_BAD.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    bcd   = BCD_BAD;
    legal = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        bcd   = BCD_BLANK;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples a multiplexed active-low 7-segment bus, debounces each digit,
// stores the committed BCD value and streams every digit change out.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [DIGITS-1:0]   an,
  input  logic [6:0]          seg,
  input  logic                err_clr,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                err,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [2:0]          upd_idx,
  output logic [3:0]          upd_bcd
);

  localparam int         IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  logic [DIGITS-1:0][3:0] cand_q, cand_d, cnt_q, cnt_d, bcd_q, bcd_d;
  logic [DIGITS-1:0]      dv_q, dv_d, pending_q, pending_d, set_mask, clr_mask;
  logic                   err_q, err_d;
  logic                   upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0]       upd_idx_q, upd_idx_d;
  logic [3:0]             upd_bcd_q, upd_bcd_d;

  logic [3:0]       dec_bcd;
  logic             dec_legal, dec_blank;
  logic [3:0]       sel_cnt;
  logic [IDX_W-1:0] sel_idx, pick_idx;
  logic             accept, pick_found;

  seg7_to_bcd u_dec (
    .seg   (seg),
    .bcd   (dec_bcd),
    .legal (dec_legal),
    .blank (dec_blank)
  );

  // A sample is only meaningful when exactly one digit enable is low.
  always_comb begin
    sel_cnt = '0;
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an[i]) begin
        sel_cnt = sel_cnt + 4'd1;
        sel_idx = IDX_W'(i);
      end
    end
    accept = sample_en && (sel_cnt == 4'd1);
  end

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    dv_d     = dv_q;
    set_mask = '0;
    err_d    = err_q & ~err_clr;
    if (accept) begin
      if (!dec_legal) begin
        cand_d[sel_idx] = BCD_BAD;
        cnt_d[sel_idx]  = 4'd0;
        err_d           = 1'b1;
      end else begin
        if (dec_bcd == cand_q[sel_idx]) begin
          if (cnt_q[sel_idx] != STABLE) cnt_d[sel_idx] = cnt_q[sel_idx] + 4'd1;
        end else begin
          cand_d[sel_idx] = dec_bcd;
          cnt_d[sel_idx]  = 4'd1;
        end
        // Once saturated the candidate already equals bcd, so this fires once per change.
        if (cnt_d[sel_idx] == STABLE && dec_bcd != bcd_q[sel_idx]) begin
          bcd_d[sel_idx]    = dec_bcd;
          dv_d[sel_idx]     = ~dec_blank;
          set_mask[sel_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    upd_valid_d = upd_valid_q;
    upd_idx_d   = upd_idx_q;
    upd_bcd_d   = upd_bcd_q;
    clr_mask    = '0;
    if (!upd_valid_q || upd_ready) begin
      upd_valid_d = pick_found;
      if (pick_found) begin
        upd_idx_d          = pick_idx;
        upd_bcd_d          = bcd_q[pick_idx];
        clr_mask[pick_idx] = 1'b1;
      end
    end
    // A commit landing on the same edge re-arms the bit so the newer value is sent.
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q      <= {DIGITS{BCD_BLANK}};
      cnt_q       <= '0;
      bcd_q       <= {DIGITS{BCD_BLANK}};
      dv_q        <= '0;
      pending_q   <= '0;
      err_q       <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_bcd_q   <= BCD_BLANK;
    end else begin
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      dv_q        <= dv_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
      upd_bcd_q   <= upd_bcd_d;
    end
  end

  assign bcd         = bcd_q;
  assign digit_valid = dv_q;
  assign err         = err_q;
  assign upd_valid   = upd_valid_q;
  assign upd_idx     = 3'(upd_idx_q);
  assign upd_bcd     = upd_bcd_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: a run-length reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_seg7_capture_decoder;

  localparam int DIGITS     = 4;
  localparam int STABLE_CNT = 3;

  localparam logic [6:0] S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000011;
  localparam logic [6:0] S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0011000;
  localparam logic [6:0] SB = 7'b1111111, SILL = 7'b0101010;
  localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000011, 7'b1111000,
                                        7'b0000000, 7'b0011000};

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                sample_en = 1'b0;
  logic [DIGITS-1:0]   an = '1;
  logic [6:0]          seg = SB;
  logic                err_clr = 1'b0;
  logic                upd_ready = 1'b0;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   digit_valid;
  logic                err, upd_valid;
  logic [2:0]          upd_idx;
  logic [3:0]          upd_bcd;

  int errors = 0;
  int checks = 0;

  seg7_capture_decoder #(.DIGITS(DIGITS), .STABLE_CNT(STABLE_CNT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .an          (an),
    .seg         (seg),
    .err_clr     (err_clr),
    .bcd         (bcd),
    .digit_valid (digit_valid),
    .err         (err),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_idx     (upd_idx),
    .upd_bcd     (upd_bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-digit run of identical legal samples, shown value,
  // pending flags and the update currently offered.
  int m_run_val [DIGITS];
  int m_run_len [DIGITS];
  int m_shown   [DIGITS];
  bit m_pend    [DIGITS];
  bit m_err, m_valid;
  int m_idx, m_ubcd;

  function automatic int glyph(input logic [6:0] s);
    if (s == SB) return 15;
    for (int v = 0; v < 10; v++) if (GLYPH[v] == s) return v;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      m_run_val[i] = 15;
      m_run_len[i] = 0;
      m_shown[i]   = 15;
      m_pend[i]    = 1'b0;
    end
    m_err = 1'b0; m_valid = 1'b0; m_idx = 0; m_ubcd = 15;
  endtask

  task automatic model_step();
    int sel_n, sel_i, g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_valid || upd_ready) begin
      m_valid = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        if (m_pend[i]) begin
          m_valid = 1'b1; m_idx = i; m_ubcd = m_shown[i]; m_pend[i] = 1'b0;
          break;
        end
      end
    end
    if (err_clr) m_err = 1'b0;
    sel_n = 0; sel_i = 0;
    for (int i = 0; i < DIGITS; i++) if (!an[i]) begin sel_n++; sel_i = i; end
    if (sample_en && sel_n == 1) begin
      g = glyph(seg);
      if (g < 0) begin
        m_run_len[sel_i] = 0; m_run_val[sel_i] = -1; m_err = 1'b1;
      end else begin
        if (g == m_run_val[sel_i]) m_run_len[sel_i]++;
        else begin m_run_val[sel_i] = g; m_run_len[sel_i] = 1; end
        if (m_run_len[sel_i] == STABLE_CNT && g != m_shown[sel_i]) begin
          m_shown[sel_i] = g; m_pend[sel_i] = 1'b1;
        end
      end
    end
  endtask

  // Accepted updates as {idx, bcd}, logged just before the accepting edge.
  logic [7:0] hs_log [$];
  logic [4*DIGITS-1:0] exp_bcd;
  logic [DIGITS-1:0]   exp_dv;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        exp_bcd[4*i +: 4] = 4'(m_shown[i]);
        exp_dv[i]         = (m_shown[i] != 15);
      end
      check("cyc_bcd", 32'(bcd), 32'(exp_bcd));
      check("cyc_digit_valid", 32'(digit_valid), 32'(exp_dv));
      check("cyc_err", 32'(err), 32'(m_err));
      check("cyc_upd_valid", 32'(upd_valid), 32'(m_valid));
      if (m_valid) begin
        check("cyc_upd_idx", 32'(upd_idx), 32'(m_idx));
        check("cyc_upd_bcd", 32'(upd_bcd), 32'(m_ubcd));
      end
      if (upd_valid && upd_ready) hs_log.push_back({1'b0, upd_idx, upd_bcd});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic samp(input int d, input logic [6:0] s);
    sample_en = 1'b1;
    an        = ~(DIGITS'(1) << d);
    seg       = s;
    tick();
    sample_en = 1'b0;
    an        = '1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    #12;
    check("rst_upd_valid", 32'(upd_valid), 32'h0);
    check("rst_upd_idx", 32'(upd_idx), 32'h0);
    check("rst_upd_bcd", 32'(upd_bcd), 32'hF);
    check("rst_bcd", 32'(bcd), 32'hFFFF);
    check("rst_digit_valid", 32'(digit_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Digit 0 shows 2 for three scans.
    upd_ready = 1'b1;
    samp(0, S2); samp(0, S2); samp(0, S2);
    check("t1_bcd0", 32'(bcd[3:0]), 32'h2);
    check("t1_dv0", 32'(digit_valid[0]), 32'h1);
    check("t1_no_upd_yet", 32'(upd_valid), 32'h0);
    tick();
    check("t1_upd_valid", 32'(upd_valid), 32'h1);
    check("t1_upd_idx", 32'(upd_idx), 32'h0);
    check("t1_upd_bcd", 32'(upd_bcd), 32'h2);
    idle(2);

    // Digit 1: broken runs must not commit.
    hs_log.delete();
    samp(1, S9); samp(1, S9); samp(1, S3);
    idle(2);
    check("t2_no_upd", 32'(hs_log.size()), 32'h0);
    samp(1, S9); samp(1, S9); samp(1, S9);
    idle(3);
    check("t2_upd_count", 32'(hs_log.size()), 32'h1);
    if (hs_log.size() == 1) check("t2_upd", 32'(hs_log[0]), 32'h19);
    check("t2_bcd", 32'(bcd), 32'hFF92);

    // Ignored samples leave counts, values and err untouched.
    hs_log.delete();
    samp(3, S4); samp(3, S4);
    sample_en = 1'b1; an = 4'b0011; seg = S4; tick();
    an = 4'b1111; seg = SILL; tick();
    sample_en = 1'b0; an = 4'b0111; seg = S4; tick();
    an = '1;
    check("t3_err", 32'(err), 32'h0);
    check("t3_bcd_held", 32'(bcd), 32'hFF92);
    check("t3_no_upd", 32'(hs_log.size()), 32'h0);
    samp(3, S4);
    check("t3_bcd_commit", 32'(bcd), 32'h4F92);
    idle(2);
    check("t3_upd_count", 32'(hs_log.size()), 32'h1);
    if (hs_log.size() == 1) check("t3_upd", 32'(hs_log[0]), 32'h34);

    // Illegal glyph on digit 2, err set/clear priority.
    hs_log.delete();
    samp(2, S1); samp(2, S1); samp(2, SILL);
    check("t4_err_set", 32'(err), 32'h1);
    samp(2, S1); samp(2, S1);
    check("t4_no_commit", 32'(bcd), 32'h4F92);
    err_clr = 1'b1; samp(2, SILL); err_clr = 1'b0;
    check("t4_err_set_wins", 32'(err), 32'h1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t4_err_clr", 32'(err), 32'h0);
    samp(2, S1); samp(2, S1);
    check("t4_still_blank", 32'(bcd[11:8]), 32'hF);
    samp(2, S1);
    check("t4_bcd", 32'(bcd), 32'h4192);
    idle(2);
    check("t4_upd_count", 32'(hs_log.size()), 32'h1);
    if (hs_log.size() == 1) check("t4_upd", 32'(hs_log[0]), 32'h21);

    // Back-pressure: digits 3 then 1 commit while the consumer stalls.
    hs_log.delete();
    upd_ready = 1'b0;
    samp(3, S5); samp(3, S5); samp(3, S5);
    samp(1, S7); samp(1, S7); samp(1, S7);
    idle(2);
    check("t5_hold_valid", 32'(upd_valid), 32'h1);
    check("t5_hold_idx", 32'(upd_idx), 32'h3);
    check("t5_hold_bcd", 32'(upd_bcd), 32'h5);
    upd_ready = 1'b1;
    idle(3);
    check("t5_upd_count", 32'(hs_log.size()), 32'h2);
    if (hs_log.size() == 2) begin
      check("t5_first", 32'(hs_log[0]), 32'h35);
      check("t5_second", 32'(hs_log[1]), 32'h17);
    end
    check("t5_drained", 32'(upd_valid), 32'h0);
    check("t5_bcd", 32'(bcd), 32'h5172);

    // Digit 0 commits 8 then blank while its update waits behind digit 2.
    hs_log.delete();
    upd_ready = 1'b0;
    samp(2, S6); samp(2, S6); samp(2, S6);
    samp(0, S8); samp(0, S8); samp(0, S8);
    samp(0, SB); samp(0, SB); samp(0, SB);
    check("t6_dv0", 32'(digit_valid[0]), 32'h0);
    check("t6_bcd0", 32'(bcd[3:0]), 32'hF);
    upd_ready = 1'b1;
    idle(4);
    check("t6_upd_count", 32'(hs_log.size()), 32'h2);
    if (hs_log.size() == 2) begin
      check("t6_first", 32'(hs_log[0]), 32'h26);
      check("t6_second", 32'(hs_log[1]), 32'h0F);
    end

    // Reset while an update is held discards it.
    upd_ready = 1'b0;
    samp(1, S3); samp(1, S3); samp(1, S3);
    tick();
    check("t7_held", 32'(upd_valid), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t7_rst_valid", 32'(upd_valid), 32'h0);
    check("t7_rst_bcd", 32'(bcd), 32'hFFFF);
    tick();
    rst_n = 1'b1;
    upd_ready = 1'b1;
    idle(2);
    samp(0, S2); samp(0, S2); samp(0, S2);
    tick();
    check("t7_after_valid", 32'(upd_valid), 32'h1);
    check("t7_after_bcd", 32'(upd_bcd), 32'h2);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
